conv_layer_sequencer: RTL

- Sequential successor to the combinational layer calculator. It walks one CNN layer (K filters, C channels, stride S, zero-padding P) as a single stream of operand pairs instead of materialising full im2col arrays.
- Reads ifmap and weights from two external single-port SRAMs with 1-cycle read latency, and inserts padding zeros on the fly.
- Emits bfloat16 (activation, weight) beats, tagged with accumulate-first/last and the ofmap address, to a downstream MAC/systolic stage over a valid/ready handshake.

---
 rtl/conv_layer_sequencer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/conv_layer_sequencer.sv
// Purpose : streams one CNN layer as (activation, weight) beat pairs read from two
//           1-cycle SRAMs, inserting zero activations for padding on the fly.
// Latency : first oValid two cycles after the start cycle (issue, then buffer write).
// Backpressure: valid/ready; issue stalls so that buffered + in-flight beats never exceed 2.
// Ports   : clk/rst_n; iStart/oBusy/oDone control; oIfmapRdEn/oIfmapAddr/iIfmapData and
//           oWeightRdEn/oWeightAddr/iWeightData SRAM ports; oValid/iReady beat handshake
//           with oAct/oWgt operands, oFirst/oLast accumulator tags and oOfmapAddr.
module conv_layer_sequencer #(
    parameter int C  = 3,
    parameter int K  = 8,
    parameter int iH = 8,
    parameter int wH = 3,
    parameter int P  = 1,
    parameter int S  = 1,
    parameter int BW = 16,
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          iStart,
    output logic          oBusy,
    output logic          oDone,
    output logic          oIfmapRdEn,
    output logic [AW-1:0] oIfmapAddr,
    input  logic [BW-1:0] iIfmapData,
    output logic          oWeightRdEn,
    output logic [AW-1:0] oWeightAddr,
    input  logic [BW-1:0] iWeightData,
    output logic          oValid,
    input  logic          iReady,
    output logic [BW-1:0] oAct,
    output logic [BW-1:0] oWgt,
    output logic          oFirst,
    output logic          oLast,
    output logic [AW-1:0] oOfmapAddr
);

    localparam int OH = (iH - wH + 2 * P) / S + 1;

    if ((iH - wH + 2 * P) < 0 || OH < 1) begin : g_bad_cfg
        $error("conv_layer_sequencer: illegal geometry, output size below 1");
    end

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef struct packed {
        logic [BW-1:0] act;
        logic [BW-1:0] wgt;
        logic          first;
        logic          last;
        logic [AW-1:0] ofa;
    } beat_t;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] kx_q, ky_q, c_q, ox_q, oy_q, k_q;
    logic [AW-1:0] kx_d, ky_d, c_d, ox_d, oy_d, k_d;
    logic [AW-1:0] ifa_hold_q;

    // Tag stage: travels alongside the SRAM read so it lines up with returned data.
    logic          infl_q, tag_pad_q, tag_first_q, tag_last_q;
    logic [AW-1:0] tag_ofa_q;

    beat_t         mem_q [2];
    logic          wr_ptr_q, rd_ptr_q;
    logic [1:0]    occ_q;

    int            y, x;
    logic          pad, pop, can_issue, issue;
    logic          max_kx, max_ky, max_c, max_ox, max_oy, max_k, last_beat;
    logic [AW-1:0] ifa_calc, wa_calc, ofa_calc;
    beat_t         wbeat, rbeat;

    function automatic logic [AW-1:0] step(input logic [AW-1:0] v, input logic inc,
                                           input logic at_max);
        return inc ? (at_max ? '0 : v + 1'b1) : v;
    endfunction

    always_comb begin
        // Signed input coordinates; negative or >= iH means a padding beat.
        y        = int'(oy_q) * S + int'(ky_q) - P;
        x        = int'(ox_q) * S + int'(kx_q) - P;
        pad      = (y < 0) || (y >= iH) || (x < 0) || (x >= iH);
        ifa_calc = AW'((int'(c_q) * iH + y) * iH + x);
        wa_calc  = AW'(((int'(k_q) * C + int'(c_q)) * wH + int'(ky_q)) * wH + int'(kx_q));
        ofa_calc = AW'((int'(k_q) * OH + int'(oy_q)) * OH + int'(ox_q));
    end

    assign max_kx    = (kx_q == AW'(wH - 1));
    assign max_ky    = (ky_q == AW'(wH - 1));
    assign max_c     = (c_q  == AW'(C - 1));
    assign max_ox    = (ox_q == AW'(OH - 1));
    assign max_oy    = (oy_q == AW'(OH - 1));
    assign max_k     = (k_q  == AW'(K - 1));
    assign last_beat = max_kx && max_ky && max_c && max_ox && max_oy && max_k;

    assign pop       = (occ_q != 2'd0) && iReady;
    // A new read may launch only if its data is guaranteed a slot next cycle.
    assign can_issue = (int'(occ_q) + int'(infl_q) - int'(pop)) <= 1;
    assign issue     = ((state_q == ST_RUN) || (state_q == ST_IDLE && iStart)) && can_issue;

    always_comb begin
        kx_d = step(kx_q, issue, max_kx);
        ky_d = step(ky_q, issue && max_kx, max_ky);
        c_d  = step(c_q,  issue && max_kx && max_ky, max_c);
        ox_d = step(ox_q, issue && max_kx && max_ky && max_c, max_ox);
        oy_d = step(oy_q, issue && max_kx && max_ky && max_c && max_ox, max_oy);
        k_d  = step(k_q,  issue && max_kx && max_ky && max_c && max_ox && max_oy, max_k);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (iStart) state_d = (issue && last_beat) ? ST_DRAIN : ST_RUN;
            ST_RUN:   if (issue && last_beat) state_d = ST_DRAIN;
            // Finish once the buffer empties this cycle and no read is still returning.
            ST_DRAIN: if (!infl_q && (occ_q == {1'b0, pop})) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wbeat       = '0;
        wbeat.act   = tag_pad_q ? '0 : iIfmapData;
        wbeat.wgt   = iWeightData;
        wbeat.first = tag_first_q;
        wbeat.last  = tag_last_q;
        wbeat.ofa   = tag_ofa_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            kx_q        <= '0;
            ky_q        <= '0;
            c_q         <= '0;
            ox_q        <= '0;
            oy_q        <= '0;
            k_q         <= '0;
            ifa_hold_q  <= '0;
            infl_q      <= 1'b0;
            tag_pad_q   <= 1'b0;
            tag_first_q <= 1'b0;
            tag_last_q  <= 1'b0;
            tag_ofa_q   <= '0;
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            occ_q       <= 2'd0;
        end else begin
            state_q <= state_d;
            kx_q    <= kx_d;
            ky_q    <= ky_d;
            c_q     <= c_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            k_q     <= k_d;
            if (issue && !pad) ifa_hold_q <= ifa_calc;
            infl_q <= issue;
            if (issue) begin
                tag_pad_q   <= pad;
                tag_first_q <= (c_q == '0) && (ky_q == '0) && (kx_q == '0);
                tag_last_q  <= max_c && max_ky && max_kx;
                tag_ofa_q   <= ofa_calc;
            end
            if (infl_q) begin
                mem_q[wr_ptr_q] <= wbeat;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            occ_q <= occ_q + {1'b0, infl_q} - {1'b0, pop};
        end
    end

    assign rbeat       = mem_q[rd_ptr_q];
    assign oIfmapRdEn  = issue && !pad;
    assign oIfmapAddr  = oIfmapRdEn ? ifa_calc : ifa_hold_q;
    assign oWeightRdEn = issue;
    assign oWeightAddr = wa_calc;
    assign oValid      = (occ_q != 2'd0);
    assign oAct        = rbeat.act;
    assign oWgt        = rbeat.wgt;
    assign oFirst      = rbeat.first;
    assign oLast       = rbeat.last;
    assign oOfmapAddr  = rbeat.ofa;
    assign oBusy       = (state_q != ST_IDLE);
    assign oDone       = (state_q == ST_DONE);

endmodule
